// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout, serializer states and the baud divisor clamp.
package mmio_uart_tx_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CLKDIV = 4'h8;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_EMPTY    = 2;
  localparam int STAT_OVERFLOW = 3;

  // A divisor below 2 cannot hold a bit for a whole baud period.
  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  function automatic logic [31:0] pack_status(input logic overflow,
                                              input logic empty,
                                              input logic full,
                                              input logic busy);
    logic [31:0] word;
    word = '0;
    word[STAT_OVERFLOW] = overflow;
    word[STAT_EMPTY]    = empty;
    word[STAT_FULL]     = full;
    word[STAT_BUSY]     = busy;
    return word;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory load/store port as seen by a memory-mapped peripheral.
interface mmio_uart_tx_if;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;

  modport master (
    output mem_write, mem_read, addr, write_data,
    input  read_data, hit
  );

  modport slave (
    input  mem_write, mem_read, addr, write_data,
    output read_data, hit
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Show-ahead circular FIFO; a push into a full FIFO is accepted only when a
// pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter on the core's load/store bus: address decode, TX FIFO,
// STATUS/CLKDIV registers and an 8N1 serializer with a registered tx line.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          DEFAULT_DIV = 16
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          tx_busy
);

  logic [31:0] offset;
  logic [3:0]  reg_off;
  logic        hit_w;
  logic        wr_txdata;
  logic        wr_status;
  logic        wr_clkdiv;
  logic [31:0] read_mux;
  logic        unused_bits;

  logic [15:0] clkdiv;
  logic        overflow;

  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  tx_state_t   state, state_d;
  logic [7:0]  shift_reg, shift_d;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_cnt, baud_d;
  logic [2:0]  bit_cnt, bit_d;
  logic        tx_q, tx_d;
  logic        baud_tick;

  // Addresses below BASE_ADDR wrap to a huge offset and so miss the window.
  assign offset  = bus.addr - BASE_ADDR;
  assign reg_off = {offset[3:2], 2'b00};
  assign hit_w   = (offset[31:4] == 28'd0) && (offset[3:2] != 2'b11);
  assign bus.hit = hit_w;

  assign wr_txdata = bus.mem_write && hit_w && (reg_off == OFF_TXDATA);
  assign wr_status = bus.mem_write && hit_w && (reg_off == OFF_STATUS);
  assign wr_clkdiv = bus.mem_write && hit_w && (reg_off == OFF_CLKDIV);

  assign unused_bits = ^{offset[1:0], bus.write_data[31:16]};

  assign tx_busy = !fifo_empty || (state != IDLE);
  assign tx      = tx_q;

  always_comb begin
    read_mux = '0;
    if (bus.mem_read && hit_w) begin
      case (reg_off)
        OFF_STATUS: read_mux = pack_status(overflow, fifo_empty, fifo_full, tx_busy);
        OFF_CLKDIV: read_mux = {16'd0, clkdiv};
        default:    read_mux = '0;
      endcase
    end
  end

  assign bus.read_data = read_mux;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .wdata (bus.write_data[7:0]),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A push while full only counts as an overflow if no pop frees a slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      clkdiv   <= 16'(DEFAULT_DIV);
      overflow <= 1'b0;
    end else begin
      if (wr_clkdiv) begin
        clkdiv <= bus.write_data[15:0];
      end
      if (wr_status) begin
        overflow <= 1'b0;
      end else if (wr_txdata && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      div_q     <= clamp_div(16'(DEFAULT_DIV));
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_d;
      shift_reg <= shift_d;
      div_q     <= div_d;
      baud_cnt  <= baud_d;
      bit_cnt   <= bit_d;
      tx_q      <= tx_d;
    end
  end

  assign baud_tick = (baud_cnt == div_q - 16'd1);

  // tx_d is the line level for the state being entered, so the registered
  // tx changes on the same edge as the state.
  always_comb begin
    state_d  = state;
    shift_d  = shift_reg;
    div_d    = div_q;
    baud_d   = baud_cnt;
    bit_d    = bit_cnt;
    tx_d     = 1'b1;
    fifo_pop = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          div_d    = clamp_div(clkdiv);
          baud_d   = '0;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_reg[0];
        end else begin
          baud_d = baud_cnt + 16'd1;
        end
      end

      DATA: begin
        tx_d = shift_reg[0];
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_cnt + 3'd1;
            tx_d  = shift_reg[1];
          end
        end else begin
          baud_d = baud_cnt + 16'd1;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_cnt + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
